// File: rtl/controlador_tablero_turnos_pkg.sv
// Shared types and constants for the tic-tac-toe board writer.
// Cell encoding, controller states, winning-line masks and the one-hot request check.
package tablero_pkg;

    typedef enum logic [1:0] {
        VACIA = 2'b00,
        J1    = 2'b01,
        J2    = 2'b10
    } celda_t;

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        TURNO_J1 = 3'd1,
        TURNO_J2 = 3'd2,
        EVALUAR  = 3'd3,
        FIN      = 3'd4
    } estado_t;

    localparam int unsigned NUM_CELDAS = 9;
    localparam int unsigned NUM_LINEAS = 8;

    // Cell i is bit i, row-major: rows, columns, then both diagonals.
    localparam logic [NUM_LINEAS-1:0][NUM_CELDAS-1:0] LINEAS = {
        9'b001_010_100,
        9'b100_010_001,
        9'b100_100_100,
        9'b010_010_010,
        9'b001_001_001,
        9'b111_000_000,
        9'b000_111_000,
        9'b000_000_111
    };

    function automatic logic es_one_hot(input logic [NUM_CELDAS-1:0] v);
        return (v != '0) && ((v & (v - 9'd1)) == '0);
    endfunction

endpackage

// File: rtl/controlador_tablero_turnos_verificador_lineas.sv
// Combinational board evaluation: line ownership for each player and full-board flag.
module verificador_lineas
    import tablero_pkg::*;
(
    input  celda_t tablero [NUM_CELDAS],
    output logic   ganaJ1,
    output logic   ganaJ2,
    output logic   lleno
);

    logic [NUM_CELDAS-1:0] dueno_j1;
    logic [NUM_CELDAS-1:0] dueno_j2;

    always_comb begin
        dueno_j1 = '0;
        dueno_j2 = '0;
        for (int unsigned i = 0; i < NUM_CELDAS; i++) begin
            dueno_j1[i] = (tablero[i] == J1);
            dueno_j2[i] = (tablero[i] == J2);
        end
    end

    always_comb begin
        ganaJ1 = 1'b0;
        ganaJ2 = 1'b0;
        for (int unsigned l = 0; l < NUM_LINEAS; l++) begin
            if ((dueno_j1 & LINEAS[l]) == LINEAS[l]) ganaJ1 = 1'b1;
            if ((dueno_j2 & LINEAS[l]) == LINEAS[l]) ganaJ2 = 1'b1;
        end
        lleno = &(dueno_j1 | dueno_j2);
    end

endmodule

// File: rtl/controlador_tablero_turnos.sv
// Board writer: turn alternation, move validation, win/draw evaluation.
// Optional per-turn timeout enabled by defining TURN_TIMEOUT_EN.
module controlador_tablero_turnos
    import tablero_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic [8:0] jugador1Habilitado,
    input  logic [8:0] jugador2Habilitado,
    output logic [1:0] pos0,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic       turno,
    output logic       jugadaAceptada,
    output logic       jugadaIlegal,
    output logic       tiempoAgotado,
    output logic [1:0] ganador,
    output logic       empate,
    output logic       fin
);

    estado_t               estado_q, estado_d;
    celda_t                tablero_q [NUM_CELDAS];
    celda_t                tablero_d [NUM_CELDAS];
    logic                  turno_q, turno_d;
    logic [1:0]            ganador_q, ganador_d;
    logic                  empate_q, empate_d;
    logic                  fin_q, fin_d;
    logic                  acept_q, acept_d;
    logic                  ilegal_q, ilegal_d;
    logic [NUM_CELDAS-1:0] peticion;
    logic [NUM_CELDAS-1:0] ocupadas;
    logic                  mueve_j2;
    logic                  gana_j1, gana_j2, lleno;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tiempo_q, tiempo_d;
`endif

    verificador_lineas u_verificador (
        .tablero (tablero_q),
        .ganaJ1  (gana_j1),
        .ganaJ2  (gana_j2),
        .lleno   (lleno)
    );

    always_comb begin
        ocupadas = '0;
        for (int unsigned i = 0; i < NUM_CELDAS; i++) begin
            ocupadas[i] = (tablero_q[i] != VACIA);
        end
    end

    // Only the current player's vector is looked at; the other is ignored entirely.
    assign mueve_j2 = (estado_q == TURNO_J2);
    assign peticion = mueve_j2 ? jugador2Habilitado : jugador1Habilitado;

    always_comb begin
        estado_d  = estado_q;
        tablero_d = tablero_q;
        turno_d   = turno_q;
        ganador_d = ganador_q;
        empate_d  = empate_q;
        acept_d   = 1'b0;
        ilegal_d  = 1'b0;
`ifdef TURN_TIMEOUT_EN
        tiempo_d  = 1'b0;
`endif
        case (estado_q)
            ESPERA: begin
                if (iniciar) estado_d = TURNO_J1;
            end
            TURNO_J1, TURNO_J2: begin
                if (peticion != '0) begin
                    if (es_one_hot(peticion) && ((peticion & ocupadas) == '0)) begin
                        for (int unsigned i = 0; i < NUM_CELDAS; i++) begin
                            if (peticion[i]) tablero_d[i] = mueve_j2 ? J2 : J1;
                        end
                        acept_d  = 1'b1;
                        estado_d = EVALUAR;
                    end else begin
                        ilegal_d = 1'b1;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                // A legal move on the terminal cycle takes priority over the forfeit.
                if (!acept_d && (cnt_q == LIMITE)) begin
                    tiempo_d = 1'b1;
                    turno_d  = ~turno_q;
                    estado_d = mueve_j2 ? TURNO_J1 : TURNO_J2;
                end
`endif
            end
            EVALUAR: begin
                // turno_q still identifies the player who just moved.
                if (turno_q ? gana_j2 : gana_j1) begin
                    estado_d  = FIN;
                    ganador_d = turno_q ? 2'b10 : 2'b01;
                end else if (lleno) begin
                    estado_d = FIN;
                    empate_d = 1'b1;
                end else begin
                    turno_d  = ~turno_q;
                    estado_d = turno_q ? TURNO_J1 : TURNO_J2;
                end
            end
            FIN: begin
                if (iniciar) begin
                    tablero_d = '{default: VACIA};
                    ganador_d = 2'b00;
                    empate_d  = 1'b0;
                    turno_d   = 1'b0;
                    estado_d  = TURNO_J1;
                end
            end
            default: estado_d = ESPERA;
        endcase
        fin_d = (estado_d == FIN);
`ifdef TURN_TIMEOUT_EN
        if (((estado_q == TURNO_J1) || (estado_q == TURNO_J2)) && (estado_d == estado_q)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= ESPERA;
            tablero_q <= '{default: VACIA};
            turno_q   <= 1'b0;
            ganador_q <= 2'b00;
            empate_q  <= 1'b0;
            fin_q     <= 1'b0;
            acept_q   <= 1'b0;
            ilegal_q  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            cnt_q     <= '0;
            tiempo_q  <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            tablero_q <= tablero_d;
            turno_q   <= turno_d;
            ganador_q <= ganador_d;
            empate_q  <= empate_d;
            fin_q     <= fin_d;
            acept_q   <= acept_d;
            ilegal_q  <= ilegal_d;
`ifdef TURN_TIMEOUT_EN
            cnt_q     <= cnt_d;
            tiempo_q  <= tiempo_d;
`endif
        end
    end

    assign pos0           = tablero_q[0];
    assign pos1           = tablero_q[1];
    assign pos2           = tablero_q[2];
    assign pos3           = tablero_q[3];
    assign pos4           = tablero_q[4];
    assign pos5           = tablero_q[5];
    assign pos6           = tablero_q[6];
    assign pos7           = tablero_q[7];
    assign pos8           = tablero_q[8];
    assign turno          = turno_q;
    assign jugadaAceptada = acept_q;
    assign jugadaIlegal   = ilegal_q;
    assign ganador        = ganador_q;
    assign empate         = empate_q;
    assign fin            = fin_q;
`ifdef TURN_TIMEOUT_EN
    assign tiempoAgotado  = tiempo_q;
`else
    assign tiempoAgotado  = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_tablero_turnos.sv
// Directed-vector bench for controlador_tablero_turnos (timeout section only with TURN_TIMEOUT_EN).
module tb_controlador_tablero_turnos;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iniciar;
    logic [8:0] req1, req2;
    logic [1:0] pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8;
    logic       turno, acept, ilegal, tiempo, empate, fin;
    logic [1:0] ganador;
    logic [17:0] tab;
    logic [17:0] tab_esp;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    controlador_tablero_turnos #(.TIMEOUT_CICLOS(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .iniciar            (iniciar),
        .jugador1Habilitado (req1),
        .jugador2Habilitado (req2),
        .pos0               (pos0),
        .pos1               (pos1),
        .pos2               (pos2),
        .pos3               (pos3),
        .pos4               (pos4),
        .pos5               (pos5),
        .pos6               (pos6),
        .pos7               (pos7),
        .pos8               (pos8),
        .turno              (turno),
        .jugadaAceptada     (acept),
        .jugadaIlegal       (ilegal),
        .tiempoAgotado      (tiempo),
        .ganador            (ganador),
        .empate             (empate),
        .fin                (fin)
    );

    assign tab = {pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1, pos0};

    task automatic comprobar(input string etiqueta, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", etiqueta, obs, esp, $time);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    // Legal move: pulse after the write edge, evaluation on the following edge.
    task automatic jugar(input int jug, input int celda);
        logic [8:0] v;
        v = 9'd1 << celda;
        if (jug == 1) req1 = v; else req2 = v;
        paso();
        tab_esp[2*celda +: 2] = (jug == 1) ? 2'b01 : 2'b10;
        comprobar("acept", 32'(acept), 32'd1);
        comprobar("tablero", 32'(tab), 32'(tab_esp));
        req1 = '0;
        req2 = '0;
        paso();
    endtask

    task automatic arrancar();
        iniciar = 1'b1;
        paso();
        iniciar = 1'b0;
        tab_esp = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        iniciar = 1'b0;
        req1    = '0;
        req2    = '0;
        tab_esp = '0;
        #12;
        comprobar("rst_tablero", 32'(tab), 32'd0);
        comprobar("rst_turno", 32'(turno), 32'd0);
        comprobar("rst_fin", 32'(fin), 32'd0);
        comprobar("rst_ganador", 32'(ganador), 32'd0);
        comprobar("rst_pulsos", 32'({acept, ilegal, tiempo, empate}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Game 1: J1 wins on row 0.
        arrancar();
        comprobar("inicio_turno", 32'(turno), 32'd0);
        jugar(1, 0);
        comprobar("turno_tras_j1", 32'(turno), 32'd1);
        comprobar("acept_un_ciclo", 32'(acept), 32'd0);

        req2 = 9'b000000001;
        paso();
        comprobar("ilegal_ocupada", 32'(ilegal), 32'd1);
        comprobar("tablero_ileg", 32'(tab), 32'h00001);
        comprobar("turno_ileg", 32'(turno), 32'd1);
        req2 = 9'b000000011;
        paso();
        comprobar("ilegal_multi", 32'(ilegal), 32'd1);
        req2 = '0;
        req1 = 9'b000100000;
        paso();
        comprobar("otro_ignorado", 32'({acept, ilegal}), 32'd0);
        comprobar("tablero_ignor", 32'(tab), 32'h00001);
        req1 = '0;

        jugar(2, 3);
        jugar(1, 1);
        jugar(2, 4);
        jugar(1, 2);
        comprobar("win_ganador", 32'(ganador), 32'd1);
        comprobar("win_fin", 32'(fin), 32'd1);
        comprobar("win_empate", 32'(empate), 32'd0);
        comprobar("win_tablero", 32'(tab), 32'h00295);

        req1 = 9'b100000000;
        req2 = 9'b100000000;
        paso();
        paso();
        comprobar("fin_ignora_tab", 32'(tab), 32'h00295);
        comprobar("fin_ignora_pul", 32'({acept, ilegal}), 32'd0);
        comprobar("fin_sostenido", 32'(fin), 32'd1);
        req1 = '0;
        req2 = '0;

        // Restart from FIN, then a full-board draw.
        arrancar();
        comprobar("reinicio_tab", 32'(tab), 32'd0);
        comprobar("reinicio_misc", 32'({ganador, empate, fin, turno}), 32'd0);
        jugar(1, 0); jugar(2, 1); jugar(1, 2); jugar(2, 4); jugar(1, 3);
        jugar(2, 5); jugar(1, 7); jugar(2, 6); jugar(1, 8);
        comprobar("empate", 32'(empate), 32'd1);
        comprobar("empate_ganador", 32'(ganador), 32'd0);
        comprobar("empate_fin", 32'(fin), 32'd1);
        comprobar("empate_tablero", 32'(tab), 32'h16A59);

        // Async reset mid-game, checked before any further clock edge.
        arrancar();
        jugar(1, 4); jugar(2, 0); jugar(1, 1); jugar(2, 2); jugar(1, 6);
        comprobar("pre_rst_turno", 32'(turno), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        comprobar("async_tablero", 32'(tab), 32'd0);
        comprobar("async_turno", 32'(turno), 32'd0);
        comprobar("async_fin", 32'(fin), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Win completed on the ninth move reports a winner, not a draw.
        arrancar();
        jugar(1, 0); jugar(2, 4); jugar(1, 1); jugar(2, 5); jugar(1, 3);
        jugar(2, 6); jugar(1, 7); jugar(2, 8); jugar(1, 2);
        comprobar("nueve_ganador", 32'(ganador), 32'd1);
        comprobar("nueve_empate", 32'(empate), 32'd0);

        arrancar();
`ifdef TURN_TIMEOUT_EN
        repeat (7) paso();
        comprobar("to_antes", 32'({tiempo, turno}), 32'd0);
        paso();
        comprobar("to_pulso", 32'(tiempo), 32'd1);
        comprobar("to_turno", 32'(turno), 32'd1);
        comprobar("to_tablero", 32'(tab), 32'd0);
        repeat (7) paso();
        req2 = 9'b000000001;
        paso();
        comprobar("to_ultimo_acept", 32'(acept), 32'd1);
        comprobar("to_ultimo_sin", 32'(tiempo), 32'd0);
        req2 = '0;
`else
        repeat (20) paso();
        comprobar("sin_timeout", 32'(tiempo), 32'd0);
        comprobar("espera_turno", 32'(turno), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
